// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 GPRs plus HI/LO, committed from MEM/WB,
// with combinational read ports that forward the in-flight WB write.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_rf_we,
  input  logic [ADDR_W-1:0] wb_rf_waddr,
  input  logic [DATA_W-1:0] wb_rf_wdata,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              gpr_wen_d;

  // r0 is hardwired to zero, so a write addressed to it never commits.
  assign gpr_wen_d = wb_rf_we && (wb_rf_waddr != '0);

  // Flop array rather than a RAM: every entry must clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (gpr_wen_d) begin
        gpr_q[wb_rf_waddr] <= wb_rf_wdata;
      end
      if (wb_whilo) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
    end
  end

  always_comb begin
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wb_rf_we && (wb_rf_waddr == raddr1)) begin
      rdata1 = wb_rf_wdata;
    end else begin
      rdata1 = gpr_q[raddr1];
    end
  end

  always_comb begin
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wb_rf_we && (wb_rf_waddr == raddr2)) begin
      rdata2 = wb_rf_wdata;
    end else begin
      rdata2 = gpr_q[raddr2];
    end
  end

  assign hi_o = wb_whilo ? wb_hi : hi_q;
  assign lo_o = wb_whilo ? wb_lo : lo_q;

  // Commit trace mirrors the WB inputs, including writes aimed at r0.
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_wen   = {4{wb_rf_we}};
  assign debug_wb_rf_wnum  = wb_rf_waddr;
  assign debug_wb_rf_wdata = wb_rf_wdata;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized
// run compared against an array-based model of the register state.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic [31:0] wb_pc;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_gpr [32];
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;
  logic [31:0] exp_q [$];

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo), .wb_pc(wb_pc),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
    ref_hi = 32'h0;
    ref_lo = 32'h0;
  endtask

  // Advance one rising edge; the model commits what the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (wb_rf_we && wb_rf_waddr != 5'd0) ref_gpr[wb_rf_waddr] = wb_rf_wdata;
      if (wb_whilo) begin
        ref_hi = wb_hi;
        ref_lo = wb_lo;
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    wb_rf_we = 1'b0; wb_rf_waddr = 5'd0; wb_rf_wdata = 32'h0;
    wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0; wb_pc = 32'h0;
  endtask

  task automatic drive_gpr_write(input logic [4:0] a, input logic [31:0] d);
    wb_rf_we = 1'b1; wb_rf_waddr = a; wb_rf_wdata = d;
  endtask

  task automatic test_reset();
    drive_idle();
    raddr1 = 5'd5; raddr2 = 5'd5;
    drive_gpr_write(5'd5, 32'hDEADBEEF);
    tick();
    drive_idle();
    #1;
    n_checks++;
    if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_prewrite got=%h exp=%h", rdata1, 32'hDEADBEEF); end
    wb_whilo = 1'b1; wb_hi = 32'h11; wb_lo = 32'h22;
    tick();
    wb_whilo = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_async_clear got=%h exp=0", rdata1); end
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
    // Writes presented while in reset must be dropped.
    drive_gpr_write(5'd6, 32'hCAFEF00D);
    wb_whilo = 1'b1; wb_hi = 32'h55; wb_lo = 32'h66;
    tick();
    drive_idle();
    raddr1 = 5'd6;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_write_ignored got=%h exp=0", rdata1); end
    n_checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_hilo_ignored got=%h/%h exp=0/0", hi_o, lo_o); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive_gpr_write(5'd7, 32'h12345678);
    tick();
    drive_idle();
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    n_checks++;
    if (rdata1 !== 32'h12345678) begin n_fail++; $display("FAIL write_read_p1 got=%h exp=%h", rdata1, 32'h12345678); end
    n_checks++;
    if (rdata2 !== 32'h12345678) begin n_fail++; $display("FAIL write_read_p2 got=%h exp=%h", rdata2, 32'h12345678); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    raddr1 = 5'd9; raddr2 = 5'd9;
    drive_gpr_write(5'd9, 32'hA5A5A5A5);
    #1;
    n_checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_p2 got=%h exp=%h", rdata2, 32'hA5A5A5A5); end
    n_checks++;
    if (rdata1 !== rdata2) begin n_fail++; $display("FAIL bypass_ports_equal got=%h exp=%h", rdata1, rdata2); end
    tick();
    drive_idle();
    #1;
    n_checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL bypass_persist got=%h exp=%h", rdata2, 32'hA5A5A5A5); end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    raddr1 = 5'd0; raddr2 = 5'd0;
    drive_gpr_write(5'd0, 32'hFFFFFFFF);
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reg0_bypass got=%h exp=0", rdata1); end
    n_checks++;
    if (debug_wb_rf_wen !== 4'hF || debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL reg0_trace got wen=%h wnum=%0d wdata=%h exp wen=f wnum=0 wdata=ffffffff", debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    tick();
    drive_idle();
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin n_fail++; $display("FAIL reg0_after got=%h/%h exp=0/0", rdata1, rdata2); end
  endtask

  task automatic test_hilo();
    @(negedge clk);
    wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
    #1;
    n_checks++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) begin n_fail++; $display("FAIL hilo_bypass got=%h/%h exp=1/2", hi_o, lo_o); end
    tick();
    wb_whilo = 1'b0; wb_hi = 32'h99; wb_lo = 32'h99;
    #1;
    n_checks++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) begin n_fail++; $display("FAIL hilo_hold got=%h/%h exp=1/2", hi_o, lo_o); end
    tick();
    n_checks++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) begin n_fail++; $display("FAIL hilo_hold_edge got=%h/%h exp=1/2", hi_o, lo_o); end
    drive_idle();
  endtask

  task automatic test_bubble_trace();
    logic [31:0] snap [32];
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 32; i++) snap[i] = ref_gpr[i];
    #1;
    n_checks++;
    if (debug_wb_rf_wen !== 4'h0 || debug_wb_pc !== 32'h0) begin n_fail++; $display("FAIL bubble_trace got wen=%h pc=%h exp wen=0 pc=0", debug_wb_rf_wen, debug_wb_pc); end
    tick();
    for (int i = 0; i < 32; i++) begin
      raddr1 = i[4:0];
      #1;
      n_checks++;
      if (rdata1 !== snap[i]) begin n_fail++; $display("FAIL bubble_state r%0d got=%h exp=%h", i, rdata1, snap[i]); end
    end
    @(negedge clk);
    wb_pc = 32'hBFC00010;
    drive_gpr_write(5'd3, 32'h0BADC0DE);
    #1;
    n_checks++;
    if (debug_wb_pc !== 32'hBFC00010 || debug_wb_rf_wnum !== 5'd3 || debug_wb_rf_wen !== 4'hF || debug_wb_rf_wdata !== 32'h0BADC0DE) begin
      n_fail++; $display("FAIL trace_commit got pc=%h wnum=%0d wen=%h wdata=%h exp pc=bfc00010 wnum=3 wen=f wdata=0badc0de", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wen, debug_wb_rf_wdata);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    raddr1 = 5'd4;
    drive_gpr_write(5'd4, 32'h44444444);
    rst = 1'b1;
    model_clear();
    tick();
    drive_idle();
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_mid_write got=%h exp=0", rdata1); end
    drive_gpr_write(5'd4, 32'h76543210);
    tick();
    drive_idle();
    #1;
    n_checks++;
    if (rdata1 !== 32'h76543210) begin n_fail++; $display("FAIL first_write_after_reset got=%h exp=%h", rdata1, 32'h76543210); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, got;
    @(negedge clk);
    for (int n = 0; n < 300; n++) begin
      wb_rf_we    = ($urandom_range(0, 3) != 0);
      wb_rf_waddr = 5'($urandom_range(0, 31));
      wb_rf_wdata = $urandom;
      wb_whilo    = ($urandom_range(0, 2) == 0);
      wb_hi       = $urandom;
      wb_lo       = $urandom;
      wb_pc       = wb_rf_we ? ($urandom & 32'hFFFFFFFC) : 32'h0;
      raddr1      = ($urandom_range(0, 3) == 0) ? wb_rf_waddr : 5'($urandom_range(0, 31));
      raddr2      = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      e1 = (raddr1 == 5'd0) ? 32'h0 : (wb_rf_we && wb_rf_waddr == raddr1) ? wb_rf_wdata : ref_gpr[raddr1];
      e2 = (raddr2 == 5'd0) ? 32'h0 : (wb_rf_we && wb_rf_waddr == raddr2) ? wb_rf_wdata : ref_gpr[raddr2];
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      exp_q.push_back(wb_whilo ? wb_hi : ref_hi);
      exp_q.push_back(wb_whilo ? wb_lo : ref_lo);
      #1;
      got = exp_q.pop_front();
      n_checks++;
      if (rdata1 !== got) begin n_fail++; $display("FAIL rand_rdata1 it=%0d got=%h exp=%h", n, rdata1, got); end
      got = exp_q.pop_front();
      n_checks++;
      if (rdata2 !== got) begin n_fail++; $display("FAIL rand_rdata2 it=%0d got=%h exp=%h", n, rdata2, got); end
      got = exp_q.pop_front();
      n_checks++;
      if (hi_o !== got) begin n_fail++; $display("FAIL rand_hi it=%0d got=%h exp=%h", n, hi_o, got); end
      got = exp_q.pop_front();
      n_checks++;
      if (lo_o !== got) begin n_fail++; $display("FAIL rand_lo it=%0d got=%h exp=%h", n, lo_o, got); end
      n_checks++;
      if (debug_wb_rf_wen !== (wb_rf_we ? 4'hF : 4'h0) || debug_wb_pc !== wb_pc) begin
        n_fail++; $display("FAIL rand_trace it=%0d got wen=%h pc=%h", n, debug_wb_rf_wen, debug_wb_pc);
      end
      tick();
    end
    drive_idle();
    for (int i = 0; i < 32; i++) begin
      raddr2 = i[4:0];
      #1;
      n_checks++;
      if (rdata2 !== ref_gpr[i]) begin n_fail++; $display("FAIL rand_final r%0d got=%h exp=%h", i, rdata2, ref_gpr[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    raddr1 = 5'd0; raddr2 = 5'd0;
    model_clear();
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      n_fail++; $display("FAIL initial_reset got=%h/%h/%h/%h exp=all 0", rdata1, rdata2, hi_o, lo_o);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_reg0();
    test_hilo();
    test_bubble_trace();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
